alu_interface: RTL and testbench
================================

# alu_interface

Sequencer between the UART byte stream and the combinational `ALU`. It collects three received words (operand A, operand B, opcode), drives them onto the ALU buses, captures the ALU result, and hands it to the UART transmitter. It initiates every ALU operation and is the only driver of the ALU inputs in the TP2 top level.

## Interface
- `length`, 8: data width; equals the UART word width and the ALU `length`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_data`  in  length  word from the UART receiver; valid only while `rx_done` is high.
- `rx_done`  in  1  one-cycle pulse: a new received word is on `rx_data`.
- `tx_done`  in  1  one-cycle pulse: the UART transmitter has finished the current word.
- `salida`  in  length  signed ALU result (combinational from `busA`, `busB`, `op`).
- `busA`  out  length  registered operand A to the ALU.
- `busB`  out  length  registered operand B to the ALU.
- `op`  out  6  registered ALU opcode.
- `tx_data`  out  length  registered result word for the transmitter.
- `tx_start`  out  1  one-cycle pulse: start transmitting `tx_data`.

## Operation
- States: `S_A`, `S_B`, `S_OP`, `S_CALC`, `S_TX`.
- `S_A`: on `rx_done`, `busA <= rx_data` and go to `S_B`; otherwise stay.
- `S_B`: on `rx_done`, `busB <= rx_data` and go to `S_OP`.
- `S_OP`: on `rx_done`, `op <= rx_data[5:0]` (upper bits discarded) and go to `S_CALC`.
- `S_CALC`: unconditional single cycle; `tx_data <= salida`, `tx_start <= 1`, go to `S_TX`.
- `S_TX`: `tx_start` is 0; wait for `tx_done`, then go to `S_A`.
- `busA`, `busB`, `op` hold their values until overwritten by the next sequence, so the ALU output stays stable during transmission.
- `rx_done` in `S_CALC` or `S_TX` is ignored: the word is dropped and nothing is buffered.
- `tx_done` in any state other than `S_TX` is ignored.
- No arithmetic is done in this block. `tx_data` is `salida` bit for bit, and an unsupported opcode returns whatever the ALU gives (0).

## Timing
- Reset (asynchronous, immediate): state `S_A`; `busA`, `busB`, `op`, `tx_data` = 0; `tx_start` = 0.
- Reset mid-sequence discards any partially loaded operands. The next received word is treated as operand A.
- An operand or opcode is visible on its output one edge after the `rx_done` cycle.
- Opcode latched at edge N. `tx_data` is valid and `tx_start` is high from edge N+1 to edge N+2, for exactly one cycle.
- `tx_done` and `rx_done` in the same cycle while in `S_TX`: return to `S_A`, and that `rx_done` word is dropped.
- Minimum turnaround: a word whose `rx_done` arrives the cycle after the `tx_done` cycle is accepted as the next operand A.
- `tx_start` is never asserted twice without an intervening `tx_done`.

## Test plan
- Add: rx 0x05, 0x03, 0x20 -> one `tx_start` pulse one cycle after the opcode latch, `tx_data` = 0x08; after `tx_done`, state `S_A`.
- Subtract with signed wrap: rx 0x03, 0x05, 0x22 -> `tx_data` = 0xFE. Also rx 0x7F, 0x01, 0x20 -> `tx_data` = 0x80.
- Opcode masking and unknown opcode: rx 0x0F, 0x0A, 0xE4 -> `op` = 0x24, `tx_data` = 0x0A. Then rx 0x11, 0x22, 0x3F -> `tx_data` = 0x00.
- Dropped input: after the opcode, pulse `rx_done` with 0x55 while in `S_TX`, then pulse `tx_done`. Send 0x01, 0x02, 0x25 -> `tx_data` = 0x03 (0x55 never loaded). Repeat with `rx_done` and `tx_done` coincident -> same result.
- Reset mid-operation: rx 0x09, assert `reset` for 2 cycles, then rx 0x04, 0x06, 0x24 -> `busA` = 0x04 and `tx_data` = 0x04. During reset all outputs read 0 immediately, without waiting for a clock edge.
- Back-to-back: three operations sent with `rx_done` the cycle after each `tx_done` -> three `tx_start` pulses with correct results (NOR of 0x0F and 0xF0 gives 0x00; shift left of 0x01 by 0x03 gives 0x08).

Source files
------------

// File: rtl/alu_interface.sv
// Sequencer between the UART byte stream and the combinational ALU.
// Collects operand A, operand B and opcode, then hands the ALU result to the transmitter.
module alu_interface #(
  parameter int unsigned length = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [length-1:0] rx_data,
  input  logic              rx_done,
  input  logic              tx_done,
  input  logic [length-1:0] salida,
  output logic [length-1:0] busA,
  output logic [length-1:0] busB,
  output logic [5:0]        op,
  output logic [length-1:0] tx_data,
  output logic              tx_start
);

  localparam int unsigned OP_W = 6;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_CALC = 3'd3,
    S_TX   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [length-1:0] busa_d, busb_d, tx_data_d;
  logic [OP_W-1:0]   op_d;
  logic              tx_start_d;

  // Next-state and next-output logic; operands hold unless a new word is accepted
  always_comb begin
    state_d    = state_q;
    busa_d     = busA;
    busb_d     = busB;
    op_d       = op;
    tx_data_d  = tx_data;
    tx_start_d = 1'b0;
    case (state_q)
      S_A: begin
        if (rx_done) begin
          busa_d  = rx_data;
          state_d = S_B;
        end
      end
      S_B: begin
        if (rx_done) begin
          busb_d  = rx_data;
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (rx_done) begin
          op_d    = rx_data[OP_W-1:0];
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        tx_data_d  = salida;
        tx_start_d = 1'b1;
        state_d    = S_TX;
      end
      S_TX: begin
        // Words received while transmitting are dropped, not buffered
        if (tx_done) state_d = S_A;
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_A;
      busA     <= '0;
      busB     <= '0;
      op       <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
    end else begin
      state_q  <= state_d;
      busA     <= busa_d;
      busB     <= busb_d;
      op       <= op_d;
      tx_data  <= tx_data_d;
      tx_start <= tx_start_d;
    end
  end

endmodule

// File: tb/tb_alu_interface.sv
// Directed bench for alu_interface with a small combinational ALU stand-in.
module tb_alu_interface;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] salida;
  logic [7:0] busA;
  logic [7:0] busB;
  logic [5:0] op;
  logic [7:0] tx_data;
  logic       tx_start;

  int unsigned n_checks;
  int unsigned n_pass;

  alu_interface #(.length(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .tx_done  (tx_done),
    .salida   (salida),
    .busA     (busA),
    .busB     (busB),
    .op       (op),
    .tx_data  (tx_data),
    .tx_start (tx_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in: MIPS-style function codes, unsupported codes give 0
  always_comb begin
    case (op)
      6'h20:   salida = busA + busB;
      6'h22:   salida = busA - busB;
      6'h24:   salida = busA & busB;
      6'h25:   salida = busA | busB;
      6'h26:   salida = busA ^ busB;
      6'h27:   salida = ~(busA | busB);
      6'h02:   salida = busA >> busB[2:0];
      6'h03:   salida = 8'($signed(busA) >>> busB[2:0]);
      6'h00:   salida = busA << busB[2:0];
      default: salida = 8'h00;
    endcase
  end

  // Present one word for one cycle; returns 1 time unit after the accepting edge
  task automatic send(input logic [7:0] w);
    rx_data = w;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic finish_tx();
    tx_done = 1'b1;
    @(posedge clk);
    #1;
    tx_done = 1'b0;
  endtask

  // Full three-word sequence; leaves the DUT waiting for tx_done
  task automatic run_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o,
                         input logic [5:0] exp_op, input logic [7:0] exp_res,
                         input string name);
    send(a);
    n_checks++;
    if (busA !== a) $display("FAIL %s busA got %h want %h", name, busA, a);
    else n_pass++;
    send(b);
    n_checks++;
    if (busB !== b) $display("FAIL %s busB got %h want %h", name, busB, b);
    else n_pass++;
    send(o);
    n_checks++;
    if (op !== exp_op || tx_start !== 1'b0)
      $display("FAIL %s op/tx_start got %h/%b want %h/0", name, op, tx_start, exp_op);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (tx_start !== 1'b1 || tx_data !== exp_res)
      $display("FAIL %s result got start=%b data=%h want start=1 data=%h",
               name, tx_start, tx_data, exp_res);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (tx_start !== 1'b0 || tx_data !== exp_res)
      $display("FAIL %s pulse_end got start=%b data=%h want start=0 data=%h",
               name, tx_start, tx_data, exp_res);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_done = 1'b0;
    #3;
    n_checks++;
    if (busA !== 8'h00 || busB !== 8'h00 || op !== 6'h00 || tx_data !== 8'h00 || tx_start !== 1'b0)
      $display("FAIL reset_state got %h %h %h %h %b want all 0", busA, busB, op, tx_data, tx_start);
    else n_pass++;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_add();
    // Stray tx_done while idle must not disturb anything
    finish_tx();
    run_seq(8'h05, 8'h03, 8'h20, 6'h20, 8'h08, "add");
    finish_tx();
  endtask

  task automatic test_sub();
    run_seq(8'h03, 8'h05, 8'h22, 6'h22, 8'hFE, "sub_wrap");
    finish_tx();
    run_seq(8'h7F, 8'h01, 8'h20, 6'h20, 8'h80, "add_overflow");
    finish_tx();
  endtask

  task automatic test_opcode_mask();
    run_seq(8'h0F, 8'h0A, 8'hE4, 6'h24, 8'h0A, "op_mask");
    finish_tx();
    run_seq(8'h11, 8'h22, 8'h3F, 6'h3F, 8'h00, "op_unknown");
    finish_tx();
  endtask

  task automatic test_dropped();
    run_seq(8'h0F, 8'h01, 8'h26, 6'h26, 8'h0E, "xor_pre_drop");
    send(8'h55);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (tx_start !== 1'b0 || busA !== 8'h0F)
      $display("FAIL drop_in_tx got start=%b busA=%h want start=0 busA=0f", tx_start, busA);
    else n_pass++;
    finish_tx();
    run_seq(8'h01, 8'h02, 8'h25, 6'h25, 8'h03, "after_drop");
    // rx_done coincident with tx_done: word is dropped
    rx_data = 8'h55;
    rx_done = 1'b1;
    tx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    tx_done = 1'b0;
    rx_data = 8'h00;
    n_checks++;
    if (busA !== 8'h01)
      $display("FAIL coincident_drop busA got %h want 01", busA);
    else n_pass++;
    run_seq(8'h01, 8'h02, 8'h25, 6'h25, 8'h03, "after_coincident");
    finish_tx();
  endtask

  task automatic test_reset_mid();
    send(8'h09);
    reset = 1'b1;
    #2;
    n_checks++;
    if (busA !== 8'h00 || tx_data !== 8'h00 || op !== 6'h00 || busB !== 8'h00 || tx_start !== 1'b0)
      $display("FAIL async_reset got %h %h %h %h %b want all 0", busA, busB, op, tx_data, tx_start);
    else n_pass++;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_seq(8'h04, 8'h06, 8'h24, 6'h24, 8'h04, "after_reset");
    finish_tx();
  endtask

  task automatic test_back_to_back();
    run_seq(8'h0F, 8'hF0, 8'h27, 6'h27, 8'h00, "b2b_nor");
    finish_tx();
    run_seq(8'h01, 8'h03, 8'h00, 6'h00, 8'h08, "b2b_sll");
    finish_tx();
    run_seq(8'h10, 8'h20, 8'h20, 6'h20, 8'h30, "b2b_add");
    finish_tx();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_add();
    test_sub();
    test_opcode_mask();
    test_dropped();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
